hilo_muldiv: RTL and testbench

- Parametrised successor to the CPU's HI/LO register pair for the five-stage MIPS pipeline.
- Holds HI/LO at width W and executes MTHI/MTLO.
- Executes MULT/MULTU in one cycle and DIV/DIVU as an iterative radix-2 divider.
- Sits beside the EX stage; raises busy to stall the pipeline while a division runs; accepts flush from the exception/branch logic.

---
 rtl/hilo_pkg.sv | 30 +++
 rtl/hilo_div_core.sv | 66 ++++++
 rtl/hilo_muldiv.sv | 163 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// op encodings, divider FSM states and a sign helper.
package hilo_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MTHI  = 3'd1;
  localparam logic [2:0] OP_MTLO  = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_MULTU = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_DIVU  = 3'd6;

  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Two's-complement negate when n is set. The low W bits of the
  // result are correct for any W <= MAXW, so callers zero-extend.
  function automatic logic [MAXW-1:0] neg_if(
    input logic [MAXW-1:0] v,
    input logic            n
  );
    return n ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/hilo_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Ports: start/dividend/divisor load, abort clears, step_done flags the last step.
module hilo_div_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         abort,
  output logic         step_done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    part;
  logic [W:0]    diff;

  always_comb begin
    part  = {rem_q, quo_q[W-1]};
    diff  = part - {1'b0, dvs_q};
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      // Borrow out of bit W means the trial subtract went negative.
      rem_d = diff[W] ? part[W-1:0] : diff[W-1:0];
      quo_d = {quo_q[W-2:0], ~diff[W]};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign step_done = (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with MTHI/MTLO, 1-cycle MULT/MULTU, iterative DIV/DIVU.
// Ports: op_valid/op/src_a/src_b issue, flush abort, busy/done status, HI/LO reads.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int W      = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  logic [2:0]   op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rHiData,
  output logic [W-1:0] rLoData
);

  state_e state_q, state_d;

  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] dza_q, dza_d;
  logic         nq_q, nq_d;
  logic         nr_q, nr_d;
  logic         dbz_q, dbz_d;
  logic         done_q, done_d;

  logic         accept;
  logic         is_div;
  logic         div_start;
  logic         step_done;
  logic         sa, sb;
  logic [W-1:0] mag_a, mag_b;
  logic [W-1:0] quo, rem;
  logic [MAXW-1:0] ta, tb, tq, tr;
  logic [2*W-1:0]  ext_a, ext_b, prod;

  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign sa     = (op == OP_DIV) && src_a[W-1];
  assign sb     = (op == OP_DIV) && src_b[W-1];
  assign ta     = neg_if(MAXW'(src_a), sa);
  assign tb     = neg_if(MAXW'(src_b), sb);
  assign mag_a  = ta[W-1:0];
  assign mag_b  = tb[W-1:0];
  assign tq     = neg_if(MAXW'(quo), nq_q);
  assign tr     = neg_if(MAXW'(rem), nr_q);

  // Sign-extend for MULT, zero-extend for MULTU; the low 2W bits
  // of the product are then correct for both.
  assign ext_a = (op == OP_MULT) ? {{W{src_a[W-1]}}, src_a}
                                 : {{W{1'b0}}, src_a};
  assign ext_b = (op == OP_MULT) ? {{W{src_b[W-1]}}, src_b}
                                 : {{W{1'b0}}, src_b};
  assign prod  = ext_a * ext_b;

  hilo_div_core #(.W(W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .abort     (flush),
    .step_done (step_done),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept && is_div)
                state_d = (src_b == '0) ? FIX : RUN;
        RUN:  if (step_done) state_d = FIX;
        FIX:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    accept    = op_valid && !busy && !flush;
    div_start = accept && is_div && (src_b != '0);
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    dza_d  = dza_q;
    nq_d   = nq_q;
    nr_d   = nr_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    if (!flush && state_q == FIX) begin
      hi_d   = dbz_q ? dza_q : tr[W-1:0];
      lo_d   = dbz_q ? '1 : tq[W-1:0];
      done_d = 1'b1;
    end
    if (accept) begin
      unique case (op)
        OP_MTHI: hi_d = src_a;
        OP_MTLO: lo_d = src_a;
        OP_MULT, OP_MULTU: begin
          hi_d = prod[2*W-1:W];
          lo_d = prod[W-1:0];
        end
        OP_DIV, OP_DIVU: begin
          nq_d  = sa ^ sb;
          nr_d  = sa;
          dbz_d = (src_b == '0);
          dza_d = src_a;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      dza_q  <= '0;
      nq_q   <= 1'b0;
      nr_q   <= 1'b0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dza_q  <= dza_d;
      nq_q   <= nq_d;
      nr_q   <= nr_d;
      dbz_q  <= dbz_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

  always_comb begin
    rHiData = hi_q;
    rLoData = lo_q;
    if (BYPASS && accept && op == OP_MTHI) rHiData = src_a;
    if (BYPASS && accept && op == OP_MTLO) rLoData = src_a;
    if (rst) begin
      rHiData = '0;
      rLoData = '0;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv (W=32, BYPASS=1).
// Drives at #1 after posedge; checks settle before the next edge.
module tb_hilo_muldiv;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] rHiData, rLoData;

  int errors = 0;
  int checks = 0;
  int n;

  hilo_muldiv #(.W(32), .BYPASS(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .rHiData  (rHiData),
    .rLoData  (rLoData)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  // The issuing side must never present an op while the unit stalls.
  always @(negedge clk) begin
    if (!rst && op_valid && busy) begin
      checks++;
      errors++;
      $error("FAIL op_valid_while_busy observed=1 expected=0");
    end
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = OP_NOP;
    src_a = '0; src_b = '0; flush = 1'b0;
    tick(); tick();
    chk("rst_hi", rHiData, 0);
    chk("rst_lo", rLoData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    issue(OP_MTHI, 32'h12345678, 0);
    #1 chk("mthi_bypass", rHiData, 32'h12345678);
    tick();
    issue(OP_MTLO, 32'hCAFEBABE, 0);
    #1 chk("mtlo_bypass", rLoData, 32'hCAFEBABE);
    chk("mtlo_hi_kept", rHiData, 32'h12345678);
    tick();
    op_valid = 1'b0;
    #1 chk("mtlo_reg", rLoData, 32'hCAFEBABE);

    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    #1 chk("mult_busy", busy, 0);
    tick();
    op_valid = 1'b0;
    #1 chk("mult_hi", rHiData, 32'hFFFFFFFF);
    chk("mult_lo", rLoData, 32'hFFFFFFFA);
    issue(OP_MULTU, 32'hFFFFFFFE, 32'd3);
    tick();
    op_valid = 1'b0;
    #1 chk("multu_hi", rHiData, 32'h00000002);
    chk("multu_lo", rLoData, 32'hFFFFFFFA);
    chk("multu_busy", busy, 0);

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    tick();
    op_valid = 1'b0;
    wait_idle(n);
    chk("div_busy_cycles", n, 33);
    chk("div_done", done, 1);
    chk("div_lo", rLoData, 32'hFFFFFFFD);
    chk("div_hi", rHiData, 32'hFFFFFFFF);
    tick();
    chk("div_done_pulse", done, 0);

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    tick();
    op_valid = 1'b0;
    wait_idle(n);
    chk("divmin_done", done, 1);
    chk("divmin_lo", rLoData, 32'h80000000);
    chk("divmin_hi", rHiData, 0);

    issue(OP_DIVU, 32'h80000000, 32'hFFFFFFFF);
    tick();
    op_valid = 1'b0;
    wait_idle(n);
    chk("divu_lo", rLoData, 0);
    chk("divu_hi", rHiData, 32'h80000000);

    issue(OP_DIVU, 32'h55, 0);
    tick();
    op_valid = 1'b0;
    wait_idle(n);
    chk("dbz_busy_cycles", n, 1);
    chk("dbz_done", done, 1);
    chk("dbz_hi", rHiData, 32'h55);
    chk("dbz_lo", rLoData, 32'hFFFFFFFF);

    issue(OP_DIV, 32'd100, 32'd7);
    tick();
    op_valid = 1'b0;
    wait_idle(n);
    chk("div100_hi", rHiData, 32'd2);
    chk("div100_lo", rLoData, 32'd14);

    issue(OP_DIV, 32'd100, 32'd7);
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    chk("flush_pre_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    tick();
    chk("flush_no_done", done, 0);
    chk("flush_hi", rHiData, 32'd2);
    chk("flush_lo", rLoData, 32'd14);

    issue(OP_MTHI, 32'hDEAD0000, 0);
    flush = 1'b1;
    #1 chk("idle_flush_read", rHiData, 32'd2);
    tick();
    flush = 1'b0;
    op_valid = 1'b0;
    #1 chk("idle_flush_hi", rHiData, 32'd2);

    issue(OP_DIV, 32'd100, 32'd7);
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1 chk("rst_read_hi", rHiData, 0);
    chk("rst_read_lo", rLoData, 0);
    tick();
    rst = 1'b0;
    #1 chk("rstdiv_busy", busy, 0);
    chk("rstdiv_done", done, 0);
    chk("rstdiv_hi", rHiData, 0);
    chk("rstdiv_lo", rLoData, 0);
    repeat (40) tick();
    chk("rstdiv_no_done", done, 0);
    chk("rstdiv_hi_late", rHiData, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
